// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: memory geometry and FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package program_loader_pkg;

  localparam int MEMORY_DEPTH = 100;
  localparam int WORD_WIDTH   = 32;
  localparam int ADDR_SHIFT   = 2;   // byte address = word index << 2
  localparam int WCNT_W       = 7;   // width of Word_Count and the word index

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/program_loader_if.sv
// Download-source and instruction-memory signals of the program loader.
// Latency: n/a (wiring only).
// Backpressure: Byte_Ready from the loader gates Byte_Valid from the source.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int Word_Width = WORD_WIDTH
) ();

  logic                  Start;
  logic [WCNT_W-1:0]     Word_Count;
  logic [7:0]            Byte_Data;
  logic                  Byte_Valid;
  logic                  Byte_Ready;
  logic                  Mem_Write_Enable;
  logic [31:0]           Mem_Write_Address;
  logic [Word_Width-1:0] Mem_Write_Data;
  logic                  CPU_Hold;
  logic                  Done;
  logic                  Error;

  // Download source / host side
  modport master (
    output Start, Word_Count, Byte_Data, Byte_Valid,
    input  Byte_Ready, Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data,
           CPU_Hold, Done, Error
  );

  // Loader side
  modport slave (
    input  Start, Word_Count, Byte_Data, Byte_Valid,
    output Byte_Ready, Mem_Write_Enable, Mem_Write_Address, Mem_Write_Data,
           CPU_Hold, Done, Error
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs four accepted bytes big-endian into one word (first byte lands in the MSBs).
// Latency: word valid the cycle after the fourth shift; last_o flags the fourth byte.
// Backpressure: none internally; shifts only when shift_i is asserted.
module byte_packer #(
  parameter int Word_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [7:0]            byte_i,
  output logic [Word_Width-1:0] word_o,
  output logic                  last_o
);

  logic [Word_Width-1:0] word_q;
  logic [1:0]            cnt_q;

  // Shift new bytes in from the bottom; the 2-bit counter wraps after the fourth byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= 2'd0;
    end else if (clr_i) begin
      word_q <= '0;
      cnt_q  <= 2'd0;
    end else if (shift_i) begin
      word_q <= {word_q[Word_Width-9:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_o = word_q;
  assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into instruction memory as big-endian words while holding the CPU.
// Latency: 4 byte cycles + 1 write cycle per word; Done the cycle after the last write.
// Backpressure: Byte_Ready is high only while collecting bytes; low during the write cycle.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int Memory_Depth = MEMORY_DEPTH,
  parameter int Word_Width   = WORD_WIDTH
) (
  input  logic           CLK,
  input  logic           RST,
  program_loader_if.slave bus
);

  logic [1:0]            state_q, state_d;
  logic [WCNT_W-1:0]     count_q, count_d;
  logic [WCNT_W-1:0]     index_q, index_d;
  logic                  error_q, error_d;
  logic                  start_seen;
  logic                  count_ok;
  logic                  load_go;
  logic                  byte_acc;
  logic                  byte_last;
  logic [Word_Width-1:0] packed_word;

  // Start is only honoured when no load is running
  assign start_seen = bus.Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign count_ok   = (bus.Word_Count != '0) && (int'(bus.Word_Count) <= Memory_Depth);
  assign load_go    = start_seen && count_ok;
  assign byte_acc   = bus.Byte_Valid && (state_q == ST_COLLECT);

  byte_packer #(.Word_Width(Word_Width)) u_packer (
    .clk     (CLK),
    .rst_n   (RST),
    .clr_i   (load_go),
    .shift_i (byte_acc),
    .byte_i  (bus.Byte_Data),
    .word_o  (packed_word),
    .last_o  (byte_last)
  );

  // Next-state logic for the load sequencer, word index and rejection flag
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_seen) begin
          if (count_ok) begin
            state_d = ST_COLLECT;
            count_d = bus.Word_Count;
            index_d = '0;
            error_d = 1'b0;
          end else begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (byte_acc && byte_last) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (index_q == count_q - 1'b1) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any load in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      index_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      error_q <= error_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once
  assign bus.Byte_Ready        = (state_q == ST_COLLECT);
  assign bus.Mem_Write_Enable  = (state_q == ST_WRITE);
  assign bus.Mem_Write_Address = 32'(index_q) << ADDR_SHIFT;
  assign bus.Mem_Write_Data    = packed_word;
  assign bus.CPU_Hold          = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign bus.Done              = (state_q == ST_DONE);
  assign bus.Error             = error_q;

endmodule
